rob_commit_unit: RTL and testbench

//  Parametrised reorder buffer with in-order, multi-wide retirement. Accepts allocations from dispatch and

---
 rtl/rob_commit_unit_if.sv | 29 ++
 rtl/rob_commit_unit.sv | 122 ++++++++++++
 tb/tb_rob_commit_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_unit_if.sv
// rob_commit_unit_if: dispatch alloc, CDB writeback, commit lanes and occupancy status of rob_commit_unit; master drives alloc/wb, slave is the ROB
interface rob_commit_unit_if #(
  parameter int TAG_W = 2, AREG_W = 3, DATA_W = 32, INSTR_W = 32, COMMIT_W = 2
);
  logic alloc_valid;
  logic [AREG_W-1:0] alloc_dest;
  logic [INSTR_W-1:0] alloc_instr;
  logic alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [DATA_W-1:0] wb_value;
  logic [COMMIT_W-1:0] cm_valid;
  logic [COMMIT_W*TAG_W-1:0] cm_tag;
  logic [COMMIT_W*AREG_W-1:0] cm_dest;
  logic [COMMIT_W*DATA_W-1:0] cm_value;
  logic [COMMIT_W*INSTR_W-1:0] cm_instr;
  logic [TAG_W:0] rob_count;
  logic rob_empty;
  logic rob_full;
  modport master(
    output alloc_valid, alloc_dest, alloc_instr, wb_valid, wb_tag, wb_value,
    input alloc_ready, alloc_tag, cm_valid, cm_tag, cm_dest, cm_value, cm_instr, rob_count, rob_empty, rob_full
  );
  modport slave(
    input alloc_valid, alloc_dest, alloc_instr, wb_valid, wb_tag, wb_value,
    output alloc_ready, alloc_tag, cm_valid, cm_tag, cm_dest, cm_value, cm_instr, rob_count, rob_empty, rob_full
  );
endinterface

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: DEPTH-entry reorder buffer retiring up to COMMIT_W done head entries per cycle; ports clk, rst_n (async low), bus (slave), flush only when ROB_FLUSH_EN is defined
module rob_commit_unit #(
  parameter int DEPTH = 4, TAG_W = 2, AREG_W = 3, DATA_W = 32, INSTR_W = 32, COMMIT_W = 2
) (
  input logic clk,
  input logic rst_n,
`ifdef ROB_FLUSH_EN
  input logic flush,
`endif
  rob_commit_unit_if.slave bus
);
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0][AREG_W-1:0] dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0] value_q, value_d;
  logic [DEPTH-1:0][INSTR_W-1:0] instr_q, instr_d;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0] count_q, count_d, k;
  logic [COMMIT_W-1:0] cm_valid_q, cm_valid_d;
  logic [COMMIT_W-1:0][TAG_W-1:0] cm_tag_q, cm_tag_d;
  logic [COMMIT_W-1:0][AREG_W-1:0] cm_dest_q, cm_dest_d;
  logic [COMMIT_W-1:0][DATA_W-1:0] cm_value_q, cm_value_d;
  logic [COMMIT_W-1:0][INSTR_W-1:0] cm_instr_q, cm_instr_d;
  logic run, alloc_fire;
  assign bus.alloc_ready = count_q != (TAG_W+1)'(DEPTH);
  assign bus.alloc_tag = tail_q;
  assign bus.rob_count = count_q;
  assign bus.rob_empty = count_q == '0;
  assign bus.rob_full = count_q == (TAG_W+1)'(DEPTH);
  assign bus.cm_valid = cm_valid_q;
  assign bus.cm_tag = cm_tag_q;
  assign bus.cm_dest = cm_dest_q;
  assign bus.cm_value = cm_value_q;
  assign bus.cm_instr = cm_instr_q;
  assign alloc_fire = bus.alloc_valid & bus.alloc_ready;
  always_comb begin
    k = '0;
    run = 1'b1;
    for (int i = 0; i < COMMIT_W; i++) begin
      run = run & valid_q[head_q + TAG_W'(i)] & done_q[head_q + TAG_W'(i)];
      k = k + (TAG_W+1)'(run);
    end
  end
  always_comb begin
    valid_d = valid_q;
    done_d = done_q;
    dest_d = dest_q;
    value_d = value_q;
    instr_d = instr_q;
    cm_valid_d = '0;
    cm_tag_d = cm_tag_q;
    cm_dest_d = cm_dest_q;
    cm_value_d = cm_value_q;
    cm_instr_d = cm_instr_q;
    head_d = head_q + k[TAG_W-1:0];
    tail_d = tail_q + TAG_W'(alloc_fire);
    count_d = count_q + (TAG_W+1)'(alloc_fire) - k;
    for (int i = 0; i < COMMIT_W; i++)
      if ((TAG_W+1)'(i) < k) begin
        cm_valid_d[i] = 1'b1;
        cm_tag_d[i] = head_q + TAG_W'(i);
        cm_dest_d[i] = dest_q[head_q + TAG_W'(i)];
        cm_value_d[i] = value_q[head_q + TAG_W'(i)];
        cm_instr_d[i] = instr_q[head_q + TAG_W'(i)];
        valid_d[head_q + TAG_W'(i)] = 1'b0;
        done_d[head_q + TAG_W'(i)] = 1'b0;
      end
    if (bus.wb_valid && valid_q[bus.wb_tag] && !done_q[bus.wb_tag]) begin
      done_d[bus.wb_tag] = 1'b1;
      value_d[bus.wb_tag] = bus.wb_value;
    end
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = bus.alloc_dest;
      instr_d[tail_q] = bus.alloc_instr;
    end
`ifdef ROB_FLUSH_EN
    if (flush) begin
      valid_d = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      cm_valid_d = '0;
      cm_tag_d = cm_tag_q;
      cm_dest_d = cm_dest_q;
      cm_value_d = cm_value_q;
      cm_instr_d = cm_instr_q;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      done_q <= '0;
      dest_q <= '0;
      value_q <= '0;
      instr_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      cm_valid_q <= '0;
      cm_tag_q <= '0;
      cm_dest_q <= '0;
      cm_value_q <= '0;
      cm_instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q <= done_d;
      dest_q <= dest_d;
      value_q <= value_d;
      instr_q <= instr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      cm_valid_q <= cm_valid_d;
      cm_tag_q <= cm_tag_d;
      cm_dest_q <= cm_dest_d;
      cm_value_q <= cm_value_d;
      cm_instr_q <= cm_instr_d;
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed self-checking bench for rob_commit_unit (DEPTH 4, COMMIT_W 2)
module tb_rob_commit_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int base;
  rob_commit_unit_if bus();
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
  rob_commit_unit dut(.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
`else
  rob_commit_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.wb_valid = 1'b0;
  endtask
  task automatic alloc(input logic [2:0] d, input logic [31:0] ins);
    bus.alloc_valid = 1'b1;
    bus.alloc_dest = d;
    bus.alloc_instr = ins;
  endtask
  task automatic wb(input logic [1:0] t, input logic [31:0] v);
    bus.wb_valid = 1'b1;
    bus.wb_tag = t;
    bus.wb_value = v;
  endtask
  initial begin
    bus.alloc_valid = 1'b0;
    bus.alloc_dest = '0;
    bus.alloc_instr = '0;
    bus.wb_valid = 1'b0;
    bus.wb_tag = '0;
    bus.wb_value = '0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_count", 64'(bus.rob_count), 64'd0);
    chk("rst_empty", 64'(bus.rob_empty), 64'd1);
    chk("rst_full", 64'(bus.rob_full), 64'd0);
    chk("rst_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_tag", 64'(bus.alloc_tag), 64'd0);
    chk("rst_cm_valid", 64'(bus.cm_valid), 64'd0);
    for (int d = 1; d <= 5; d++) begin
      alloc(3'(d), 32'h100 + 32'(d));
      chk("t1_ready", 64'(bus.alloc_ready), 64'(d <= 4));
      chk("t1_tag", 64'(bus.alloc_tag), d <= 4 ? 64'(d - 1) : 64'd0);
      tick();
      chk("t1_count", 64'(bus.rob_count), d <= 4 ? 64'(d) : 64'd4);
      chk("t1_full", 64'(bus.rob_full), 64'(d >= 4));
    end
    idle();
    wb(2, 32'hAA);
    tick();
    chk("t2_wb2_cm", 64'(bus.cm_valid), 64'd0);
    wb(1, 32'hBB);
    tick();
    chk("t2_wb1_cm", 64'(bus.cm_valid), 64'd0);
    wb(0, 32'hCC);
    tick();
    chk("t2_wb0_cm", 64'(bus.cm_valid), 64'd0);
    idle();
    tick();
    chk("t2_cm_valid", 64'(bus.cm_valid), 64'd3);
    chk("t2_cm_tag", 64'(bus.cm_tag), 64'b0100);
    chk("t2_cm_value", 64'(bus.cm_value), 64'h000000BB_000000CC);
    chk("t2_cm_dest", 64'(bus.cm_dest), 64'b010_001);
    chk("t2_cm_instr", 64'(bus.cm_instr), 64'h00000102_00000101);
    chk("t2_count", 64'(bus.rob_count), 64'd2);
    tick();
    chk("t2b_cm_valid", 64'(bus.cm_valid), 64'd1);
    chk("t2b_cm_tag", 64'(bus.cm_tag), 64'b0110);
    chk("t2b_cm_value", 64'(bus.cm_value[31:0]), 64'hAA);
    chk("t2b_cm_dest", 64'(bus.cm_dest[2:0]), 64'd3);
    chk("t2b_count", 64'(bus.rob_count), 64'd1);
    alloc(6, 32'h106);
    chk("t3_tag", 64'(bus.alloc_tag), 64'd0);
    tick();
    idle();
    chk("t3_count", 64'(bus.rob_count), 64'd2);
    wb(0, 32'h44);
    tick();
    chk("t3_wb0_cm", 64'(bus.cm_valid), 64'd0);
    wb(3, 32'h33);
    tick();
    chk("t3_wb3_cm", 64'(bus.cm_valid), 64'd0);
    idle();
    tick();
    chk("t3_cm_valid", 64'(bus.cm_valid), 64'd3);
    chk("t3_cm_tag", 64'(bus.cm_tag), 64'b0011);
    chk("t3_cm_value", 64'(bus.cm_value), 64'h00000044_00000033);
    chk("t3_cm_dest", 64'(bus.cm_dest), 64'b110_100);
    chk("t3_empty", 64'(bus.rob_empty), 64'd1);
    chk("t3_alloc_tag", 64'(bus.alloc_tag), 64'd1);
    for (int d = 1; d <= 3; d++) begin
      alloc(3'(d), 32'h200 + 32'(d));
      tick();
    end
    idle();
    chk("t4_count3", 64'(bus.rob_count), 64'd3);
    wb(1, 32'h55);
    tick();
    chk("t4_wb1_cm", 64'(bus.cm_valid), 64'd0);
    alloc(7, 32'h107);
    wb(0, 32'h99);
    chk("t4_tag_pre", 64'(bus.alloc_tag), 64'd0);
    tick();
    idle();
    chk("t4_count", 64'(bus.rob_count), 64'd3);
    chk("t4_cm_valid", 64'(bus.cm_valid), 64'd1);
    chk("t4_cm_tag", 64'(bus.cm_tag[1:0]), 64'd1);
    chk("t4_cm_value", 64'(bus.cm_value[31:0]), 64'h55);
    chk("t4_tag_post", 64'(bus.alloc_tag), 64'd1);
    wb(0, 32'h11);
    tick();
    chk("t5_wb11_cm", 64'(bus.cm_valid), 64'd0);
    wb(0, 32'h22);
    tick();
    chk("t5_wb22_cm", 64'(bus.cm_valid), 64'd0);
    wb(2, 32'hA2);
    tick();
    chk("t5_wb2_cm", 64'(bus.cm_valid), 64'd0);
    wb(3, 32'hA3);
    tick();
    chk("t5_k1_valid", 64'(bus.cm_valid), 64'd1);
    chk("t5_k1_value", 64'(bus.cm_value[31:0]), 64'hA2);
    idle();
    tick();
    chk("t5_cm_valid", 64'(bus.cm_valid), 64'd3);
    chk("t5_cm_tag", 64'(bus.cm_tag), 64'b0011);
    chk("t5_cm_value", 64'(bus.cm_value), 64'h00000011_000000A3);
    chk("t5_cm_dest", 64'(bus.cm_dest), 64'b111_011);
    chk("t5_cm_instr", 64'(bus.cm_instr), 64'h00000107_00000203);
    chk("t5_count", 64'(bus.rob_count), 64'd0);
    wb(1, 32'h77);
    tick();
    idle();
    chk("t5_empty_wb_count", 64'(bus.rob_count), 64'd0);
    chk("t5_empty_wb_cm", 64'(bus.cm_valid), 64'd0);
    alloc(5, 32'h305);
    chk("t5_tag1", 64'(bus.alloc_tag), 64'd1);
    tick();
    idle();
    tick();
    chk("t5_not_done_cm", 64'(bus.cm_valid), 64'd0);
    chk("t5_not_done_count", 64'(bus.rob_count), 64'd1);
    wb(1, 32'h78);
    tick();
    idle();
    tick();
    chk("t5_late_valid", 64'(bus.cm_valid), 64'd1);
    chk("t5_late_value", 64'(bus.cm_value[31:0]), 64'h78);
    base = 2;
`ifdef ROB_FLUSH_EN
    for (int d = 1; d <= 3; d++) begin
      alloc(3'(d), 32'h400 + 32'(d));
      tick();
    end
    idle();
    chk("t6_count3", 64'(bus.rob_count), 64'd3);
    wb(2, 32'h66);
    tick();
    idle();
    alloc(4, 32'h404);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t6_count", 64'(bus.rob_count), 64'd0);
    chk("t6_empty", 64'(bus.rob_empty), 64'd1);
    chk("t6_cm_valid", 64'(bus.cm_valid), 64'd0);
    chk("t6_alloc_tag", 64'(bus.alloc_tag), 64'd0);
    alloc(5, 32'h405);
    tick();
    idle();
    wb(0, 32'h5A);
    tick();
    idle();
    tick();
    chk("t6_after_valid", 64'(bus.cm_valid), 64'd1);
    chk("t6_after_tag", 64'(bus.cm_tag[1:0]), 64'd0);
    chk("t6_after_value", 64'(bus.cm_value[31:0]), 64'h5A);
    base = 1;
`endif
    alloc(1, 32'h501);
    tick();
    alloc(2, 32'h502);
    tick();
    idle();
    wb(2'(base + 1), 32'h61);
    tick();
    wb(2'(base), 32'h60);
    tick();
    idle();
    tick();
    chk("t7_pre_valid", 64'(bus.cm_valid), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t7_cm_valid", 64'(bus.cm_valid), 64'd0);
    chk("t7_cm_tag", 64'(bus.cm_tag), 64'd0);
    chk("t7_cm_value", 64'(bus.cm_value), 64'd0);
    chk("t7_count", 64'(bus.rob_count), 64'd0);
    chk("t7_empty", 64'(bus.rob_empty), 64'd1);
    chk("t7_ready", 64'(bus.alloc_ready), 64'd1);
    chk("t7_tag", 64'(bus.alloc_tag), 64'd0);
    #10 rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
